// File: rtl/mprj_console_tx_if.sv
// Byte-input handshake for the console transmitter: the producer drives
// valid/data, the transmitter answers with ready.
interface mprj_console_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/mprj_console_tx.sv
// Console transmitter: buffers bytes in a FIFO and replays each one on a
// parallel bus with a shaped strobe (setup / strobe / hold), halting on EOT.
module mprj_console_tx #(
  parameter int         DATA_W        = 8,
  parameter int         DEPTH         = 16,
  parameter int         SETUP_CYCLES  = 2,
  parameter int         STROBE_CYCLES = 4,
  parameter int         HOLD_CYCLES   = 2,
  parameter logic [7:0] EOT_CHAR      = 8'h04
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  mprj_console_tx_if.slave         in_if,
  input  logic                     clear_i,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_strobe,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     eot
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_HALT
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] out_data_q;
  logic              strobe_q;
  logic              eot_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic              in_ready;
  logic              push;
  logic              pop;
  logic              phase_last;
  logic              is_eot_byte;
  logic              hold_done;
  logic [DATA_W-1:0] head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = !fifo_full && !eot_q;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // A push coinciding with a flush is discarded rather than surviving it.
  assign push = in_if.in_valid && in_ready && !clear_i;

  assign is_eot_byte = (out_data_q[7:0] == EOT_CHAR);
  assign hold_done   = (state_q == ST_HOLD) && phase_last;
  assign pop = !fifo_empty && !clear_i &&
               ((state_q == ST_IDLE) || (hold_done && !is_eot_byte));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (in_if.in_valid && !in_ready && !eot_q) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; zeroed pointers make stale entries unreachable.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_if.in_data;
  end

  // ---------------------------------------------------------------------------
  // Output sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_last = 1'b0;
    case (state_q)
      ST_SETUP:  phase_last = (cnt_q == CW'(SETUP_CYCLES - 1));
      ST_STROBE: phase_last = (cnt_q == CW'(STROBE_CYCLES - 1));
      ST_HOLD:   phase_last = (cnt_q == CW'(HOLD_CYCLES - 1));
      default:   phase_last = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      out_data_q <= '0;
      strobe_q   <= 1'b0;
      eot_q      <= 1'b0;
    end else begin
      if (clear_i) eot_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            out_data_q <= head;
            cnt_q      <= '0;
            state_q    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (phase_last) begin
            cnt_q    <= '0;
            strobe_q <= 1'b1;
            state_q  <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_STROBE: begin
          if (phase_last) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            state_q  <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        // A flush landing on the final hold cycle overrides EOT entry.
        ST_HOLD: begin
          if (phase_last) begin
            cnt_q <= '0;
            if (is_eot_byte && !clear_i) begin
              eot_q   <= 1'b1;
              state_q <= ST_HALT;
            end else if (pop) begin
              out_data_q <= head;
              state_q    <= ST_SETUP;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_HALT: begin
          if (clear_i) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_if.in_ready = in_ready;
  assign out_data       = out_data_q;
  assign out_strobe     = strobe_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;
  assign level          = wr_ptr_q - rd_ptr_q;
  assign overflow       = overflow_q;
  assign eot            = eot_q;

endmodule

// File: tb/tb_mprj_console_tx.sv
// Directed bench for mprj_console_tx: default build, a DEPTH=4 build for
// overflow, and a 16-bit single-cycle-phase build for the wide EOT case.
module tb_mprj_console_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults
  mprj_console_tx_if #(.DATA_W(8)) a_if ();
  logic       a_clear;
  logic [7:0] a_out_data;
  logic       a_strobe, a_busy, a_ovf, a_eot;
  logic [4:0] a_level;

  mprj_console_tx dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_if(a_if), .clear_i(a_clear),
    .out_data(a_out_data), .out_strobe(a_strobe), .busy(a_busy),
    .level(a_level), .overflow(a_ovf), .eot(a_eot)
  );

  // Instance B: shallow FIFO
  mprj_console_tx_if #(.DATA_W(8)) b_if ();
  logic       b_clear;
  logic [7:0] b_out_data;
  logic       b_strobe, b_busy, b_ovf, b_eot;
  logic [2:0] b_level;

  mprj_console_tx #(.DEPTH(4)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_if(b_if), .clear_i(b_clear),
    .out_data(b_out_data), .out_strobe(b_strobe), .busy(b_busy),
    .level(b_level), .overflow(b_ovf), .eot(b_eot)
  );

  // Instance C: 16-bit, one cycle per phase
  mprj_console_tx_if #(.DATA_W(16)) c_if ();
  logic        c_clear;
  logic [15:0] c_out_data;
  logic        c_strobe, c_busy, c_ovf, c_eot;
  logic [4:0]  c_level;

  mprj_console_tx #(.DATA_W(16), .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut_c (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_if(c_if), .clear_i(c_clear),
    .out_data(c_out_data), .out_strobe(c_strobe), .busy(c_busy),
    .level(c_level), .overflow(c_ovf), .eot(c_eot)
  );

  // Strobe monitors: capture data and cycle at each rising strobe
  logic [7:0]  a_mon_d[$];
  int          a_mon_c[$];
  logic [7:0]  b_mon_d[$];
  int          b_mon_c[$];
  logic [15:0] c_mon_d[$];
  int          c_mon_c[$];

  always @(posedge a_strobe) begin a_mon_d.push_back(a_out_data); a_mon_c.push_back(cyc); end
  always @(posedge b_strobe) begin b_mon_d.push_back(b_out_data); b_mon_c.push_back(cyc); end
  always @(posedge c_strobe) begin c_mon_d.push_back(c_out_data); c_mon_c.push_back(cyc); end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  logic [15:0] wide  [3] = '{16'h0041, 16'h0042, 16'h1204};
  int peak;

  initial begin
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_clear = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_clear = 1'b0;
    c_if.in_valid = 1'b0; c_if.in_data = '0; c_clear = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_out_data", a_out_data, 8'h00);
    check("rst_strobe",   a_strobe,   1'b0);
    check("rst_in_ready", a_if.in_ready, 1'b1);
    check("rst_busy",     a_busy,     1'b0);
    check("rst_level",    a_level,    5'd0);
    check("rst_overflow", a_ovf,      1'b0);
    check("rst_eot",      a_eot,      1'b0);

    // Single byte latency: push at edge N, samples after N+k
    a_if.in_valid = 1'b1; a_if.in_data = 8'h41;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    check("lat_level_n",  a_level,  5'd1);
    check("lat_strobe_n", a_strobe, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) check("lat_level_pop", a_level, 5'd0);
      check($sformatf("lat_data_%0d", k),   a_out_data, 8'h41);
      check($sformatf("lat_strobe_%0d", k), a_strobe, (k >= 3 && k <= 6) ? 1'b1 : 1'b0);
      check($sformatf("lat_busy_%0d", k),   a_busy,   (k <= 8) ? 1'b1 : 1'b0);
    end

    // HELLO back-to-back
    a_mon_d.delete(); a_mon_c.delete(); peak = 0;
    for (int i = 0; i < 5; i++) begin
      a_if.in_valid = 1'b1; a_if.in_data = hello[i];
      @(negedge clk);
      if (int'(a_level) > peak) peak = int'(a_level);
    end
    a_if.in_valid = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (int'(a_level) > peak) peak = int'(a_level);
    end
    check("hello_count", a_mon_d.size(), 5);
    check("hello_peak",  peak, 4);
    check("hello_busy",  a_busy, 1'b0);
    for (int i = 0; i < a_mon_d.size() && i < 5; i++) begin
      check($sformatf("hello_char_%0d", i), a_mon_d[i], hello[i]);
      if (i > 0) check($sformatf("hello_gap_%0d", i), a_mon_c[i] - a_mon_c[i-1], 8);
    end

    // EOT: 0x58, 0x04, 0x59 pushed at N, N+1, N+2
    a_mon_d.delete(); a_mon_c.delete();
    a_if.in_valid = 1'b1; a_if.in_data = 8'h58; @(negedge clk);
    a_if.in_data = 8'h04; @(negedge clk);
    a_if.in_data = 8'h59; @(negedge clk);
    a_if.in_valid = 1'b0;
    repeat (13) @(negedge clk);
    @(negedge clk);
    check("eot_before", a_eot, 1'b0);
    @(negedge clk);
    check("eot_rise",     a_eot, 1'b1);
    check("eot_in_ready", a_if.in_ready, 1'b0);
    check("eot_level",    a_level, 5'd1);
    check("eot_out_data", a_out_data, 8'h04);
    check("eot_busy",     a_busy, 1'b1);
    repeat (20) @(negedge clk);
    check("eot_strobes", a_mon_d.size(), 2);
    for (int i = 0; i < a_mon_d.size() && i < 2; i++)
      check($sformatf("eot_char_%0d", i), a_mon_d[i], (i == 0) ? 8'h58 : 8'h04);
    a_if.in_valid = 1'b1; a_if.in_data = 8'h77; @(negedge clk);
    a_if.in_valid = 1'b0;
    check("eot_drop_ovf",   a_ovf,   1'b0);
    check("eot_drop_level", a_level, 5'd1);
    a_clear = 1'b1; @(negedge clk);
    a_clear = 1'b0;
    check("clr_level",    a_level, 5'd0);
    check("clr_eot",      a_eot,   1'b0);
    check("clr_busy",     a_busy,  1'b0);
    check("clr_in_ready", a_if.in_ready, 1'b1);

    // Asynchronous reset during STROBE
    a_if.in_valid = 1'b1; a_if.in_data = 8'h33; @(negedge clk);
    a_if.in_data = 8'h34; @(negedge clk);
    a_if.in_valid = 1'b0;
    for (int k = 0; k < 20 && !a_strobe; k++) @(negedge clk);
    check("arst_pre_strobe", a_strobe, 1'b1);
    check("arst_pre_level",  a_level,  5'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_strobe",   a_strobe,   1'b0);
    check("arst_out_data", a_out_data, 8'h00);
    check("arst_level",    a_level,    5'd0);
    check("arst_busy",     a_busy,     1'b0);
    check("arst_in_ready", a_if.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    a_mon_d.delete(); a_mon_c.delete();
    @(negedge clk);
    a_if.in_valid = 1'b1; a_if.in_data = 8'h4B; @(negedge clk);
    a_if.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_after_count", a_mon_d.size(), 1);
    if (a_mon_d.size() > 0) check("arst_after_char", a_mon_d[0], 8'h4B);

    // Overflow on DEPTH=4: six pushes on consecutive edges
    b_mon_d.delete(); b_mon_c.delete();
    for (int i = 0; i < 6; i++) begin
      b_if.in_valid = 1'b1; b_if.in_data = 8'hA0 + 8'(i);
      @(negedge clk);
      if (i == 4) begin
        check("ovf_full_level", b_level, 3'd4);
        check("ovf_full_ready", b_if.in_ready, 1'b0);
        check("ovf_not_yet",    b_ovf, 1'b0);
      end
    end
    b_if.in_valid = 1'b0;
    check("ovf_set",        b_ovf,   1'b1);
    check("ovf_level_held", b_level, 3'd4);
    repeat (45) @(negedge clk);
    check("ovf_count", b_mon_d.size(), 5);
    for (int i = 0; i < b_mon_d.size() && i < 5; i++) begin
      check($sformatf("ovf_char_%0d", i), b_mon_d[i], 8'hA0 + 8'(i));
      if (i > 0) check($sformatf("ovf_gap_%0d", i), b_mon_c[i] - b_mon_c[i-1], 8);
    end
    b_clear = 1'b1; b_if.in_valid = 1'b1; b_if.in_data = 8'hEE;
    @(negedge clk);
    b_clear = 1'b0; b_if.in_valid = 1'b0;
    check("clrpush_level", b_level, 3'd0);
    check("clrpush_ovf",   b_ovf,   1'b0);
    repeat (12) @(negedge clk);
    check("clrpush_count", b_mon_d.size(), 5);
    check("clrpush_busy",  b_busy, 1'b0);

    // Wide build, 3-cycle period, EOT on low byte of 0x1204
    c_mon_d.delete(); c_mon_c.delete();
    for (int i = 0; i < 3; i++) begin
      c_if.in_valid = 1'b1; c_if.in_data = wide[i];
      @(negedge clk);
    end
    c_if.in_valid = 1'b0;
    check("wide_strobe_hi", c_strobe, 1'b1);
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) check("wide_strobe_lo", c_strobe, 1'b0);
      if (k == 9) check("wide_eot_before", c_eot, 1'b0);
    end
    check("wide_eot",      c_eot, 1'b1);
    check("wide_in_ready", c_if.in_ready, 1'b0);
    check("wide_out_data", c_out_data, 16'h1204);
    check("wide_count",    c_mon_d.size(), 3);
    for (int i = 0; i < c_mon_d.size() && i < 3; i++) begin
      check($sformatf("wide_char_%0d", i), c_mon_d[i], wide[i]);
      if (i > 0) check($sformatf("wide_gap_%0d", i), c_mon_c[i] - c_mon_c[i-1], 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mprj_console_tx.md
# mprj_console_tx

Parametrised hardware console transmitter for the user project area. It accepts bytes from on-chip logic through a valid/ready port and buffers them in a FIFO. It then presents each byte on a parallel `mprj_io` data bus, qualified by a strobe pin, so the simulation monitor can print firmware/accelerator output by sampling data on the strobe's rising edge. It generalises the fixed 8-bit printf/end-of-test convention with configurable width, buffering, strobe shaping and end-of-test (EOT) detection.

## Interface
- `DATA_W`, 8: console character width in bits.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `SETUP_CYCLES`, 2: cycles data is stable before the strobe rises; ≥1.
- `STROBE_CYCLES`, 4: cycles the strobe is high; ≥1.
- `HOLD_CYCLES`, 2: cycles data is held after the strobe falls; ≥1.
- `EOT_CHAR`, 8'h04: end-of-test code, compared on the low 8 bits.
- `wb_clk_i`  in  1  single system clock.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte offered.
- `in_data`  in  DATA_W  byte to print.
- `in_ready`  out  1  `!full && !eot`.
- `clear_i`  in  1  one-cycle pulse: flush FIFO, clear `overflow` and `eot`.
- `out_data`  out  DATA_W  to `mprj_io` data pins.
- `out_strobe`  out  1  to the strobe pin; the monitor samples on its rising edge.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: a push was attempted while `in_ready` was low and `eot` was 0.
- `eot`  out  1  sticky: the EOT character has completed its strobe.

## Operation
- Push happens on `in_valid && in_ready` at a clock edge. `in_ready` comes from registered state only. A push while full is rejected even if a pop occurs in the same cycle.
- A rejected push while `eot`=0 sets `overflow`. Pushes while `eot`=1 are silently dropped.
- Output FSM states: IDLE, SETUP, STROBE, HOLD, HALT.
  - IDLE: if the FIFO is non-empty, pop the head into `out_data` and go to SETUP.
  - SETUP: strobe low for SETUP_CYCLES, then go to STROBE.
  - STROBE: strobe high for STROBE_CYCLES, then go to HOLD.
  - HOLD: strobe low and data held for HOLD_CYCLES. On the last HOLD cycle:
    - if the byte equals EOT_CHAR, set `eot` and go to HALT;
    - else if the FIFO is non-empty, pop directly into SETUP (no IDLE bubble);
    - else go to IDLE.
  - HALT: no further pops. Queued bytes are retained, and `out_data` keeps the EOT byte.
- `out_data` changes only on a pop; it is never modified during STROBE or HOLD.
- `clear_i`:
  - empties the FIFO and clears `overflow` and `eot`;
  - HALT goes to IDLE;
  - an in-flight byte (SETUP/STROBE/HOLD) completes normally and is not aborted;
  - a push in the same cycle as `clear_i` is discarded, and `overflow` is not set.
- Simultaneous push and pop when not full: both occur, and `level` is unchanged.
- FIFO pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full is signalled when the pointer MSBs differ and the low bits are equal.

## Timing
- Reset values: `out_data`=0, `out_strobe`=0, `in_ready`=1, `busy`=0, `level`=0, `overflow`=0, `eot`=0, FSM=IDLE, pointers=0.
- Reset asserted mid-byte drops `out_strobe` low asynchronously and discards all content.
- Latency, with a push accepted at edge N into an empty FIFO and the FSM in IDLE:
  - `level`=1 after N;
  - pop at N+1, with `out_data` valid after N+1;
  - `out_strobe` rises after edge N+1+SETUP_CYCLES;
  - `out_strobe` falls STROBE_CYCLES later.
- Back-to-back byte period is SETUP+STROBE+HOLD cycles (8 at defaults).
- `eot` rises on the edge ending the last HOLD cycle of the EOT byte.
- `overflow` rises on the edge of the rejected push.

## Test plan
- Reset, then push 0x41 at edge 5 (defaults) -> `out_data`=0x41 from edge 6; `out_strobe` high on edges 8–11 only; `busy` low after edge 14.
- Push "HELLO" on 5 consecutive cycles -> 5 strobes spaced exactly 8 cycles apart; `level` peaks at 4; monitor prints "HELLO".
- Hold the output (DEPTH=4), push 6 bytes without waiting -> `in_ready` low when `level`=4; 1 byte dropped; `overflow`=1; the surviving bytes are printed in order.
- Push 0x58, 0x04, 0x59 -> 0x58 and 0x04 strobed; `eot`=1 after the 0x04 HOLD; 0x59 never strobed; `in_ready`=0; `clear_i` -> `level`=0, IDLE, `eot`=0.
- Assert `wb_rst_i` during STROBE -> `out_strobe` falls before the next clock edge; all outputs at reset values; a new push afterwards prints normally.
- DATA_W=16, SETUP_CYCLES=1, STROBE_CYCLES=1, HOLD_CYCLES=1, push 0x1204 -> strobed with the 3-cycle period; `eot` set (low byte 0x04).
